// File: rtl/dot_score_keeper.sv
// rtl/dot_score_keeper.sv - dot-eaten detection, BCD scoring, dots-left and level-clear sequencing
// Sits between the dot grid and the score/HUD renderer.
module dot_score_keeper #(
  parameter int DOT_POINTS  = 10,
  parameter int CLEAR_DELAY = 120,
  parameter int RELOAD_LEN  = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         frame_tick_i,
  input  logic [143:0] dot_display_i,
  input  logic         level_status_i,
  output logic [19:0]  score_bcd_o,
  output logic [7:0]   dots_left_o,
  output logic [3:0]   level_num_o,
  output logic         level_clear_o,
  output logic         dots_reset_o
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RELOAD = 2'd3;

  localparam logic [19:0] PTS_BCD     = {12'd0, 4'(DOT_POINTS / 10), 4'(DOT_POINTS % 10)};
  localparam logic [7:0]  DELAY_LAST  = 8'(CLEAR_DELAY - 1);
  localparam logic [7:0]  RELOAD_LAST = 8'(RELOAD_LEN - 1);

  logic [1:0]   state_q, state_d;
  logic [143:0] prev_map_q;
  logic [7:0]   pending_q, pending_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [19:0]  score_q, score_d;
  logic [7:0]   dots_left_q, dots_left_d;
  logic [3:0]   level_q, level_d;

  logic [7:0]  n_eaten;
  logic [7:0]  n_live;
  logic [8:0]  pend_sum;
  logic [7:0]  pend_next;
  logic [7:0]  dots_sub;
  logic [19:0] score_add;
  logic        bcd_carry;
  logic [4:0]  digit_sum;

  function automatic logic [7:0] popcount144(input logic [143:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 144; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  assign n_eaten = popcount144(prev_map_q & ~dot_display_i);
  assign n_live  = popcount144(dot_display_i);

  // One dot retires per cycle while new ones add in; the result saturates at 255.
  assign pend_sum  = {1'b0, pending_q} + {1'b0, n_eaten} - {8'd0, pending_q != 8'd0};
  assign pend_next = pend_sum[8] ? 8'hFF : pend_sum[7:0];
  assign dots_sub  = (n_eaten > dots_left_q) ? 8'd0 : dots_left_q - n_eaten;

  always_comb begin
    bcd_carry = 1'b0;
    digit_sum = '0;
    score_add = '0;
    for (int d = 0; d < 5; d++) begin
      digit_sum = {1'b0, score_q[4*d +: 4]} + {1'b0, PTS_BCD[4*d +: 4]} + {4'd0, bcd_carry};
      if (digit_sum > 5'd9) begin
        score_add[4*d +: 4] = 4'(digit_sum - 5'd10);
        bcd_carry = 1'b1;
      end else begin
        score_add[4*d +: 4] = digit_sum[3:0];
        bcd_carry = 1'b0;
      end
    end
    // A carry out of the top digit means the true sum passed 99999.
    if (bcd_carry) score_add = 20'h99999;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    dots_left_d = dots_left_q;
    level_d     = level_q;
    score_d     = (pending_q != 8'd0) ? score_add : score_q;
    case (state_q)
      S_INIT: begin
        dots_left_d = n_live;
        pending_d   = 8'd0;
        state_d     = S_PLAY;
      end
      S_PLAY: begin
        pending_d   = pend_next;
        dots_left_d = dots_sub;
        if (!level_status_i && pending_q == 8'd0 && n_eaten == 8'd0) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        if (frame_tick_i) begin
          if (cnt_q == DELAY_LAST) begin
            state_d = S_RELOAD;
            cnt_d   = 8'd0;
            level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        if (cnt_q == RELOAD_LAST) state_d = S_INIT;
        else cnt_d = cnt_q + 8'd1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      prev_map_q  <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
      score_q     <= '0;
      dots_left_q <= '0;
      level_q     <= 4'd1;
    end else begin
      state_q     <= state_d;
      prev_map_q  <= dot_display_i;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      score_q     <= score_d;
      dots_left_q <= dots_left_d;
      level_q     <= level_d;
    end
  end

  assign score_bcd_o   = score_q;
  assign dots_left_o   = dots_left_q;
  assign level_num_o   = level_q;
  assign level_clear_o = (state_q == S_WAIT);
  assign dots_reset_o  = (state_q == S_RELOAD);

endmodule

// File: tb/tb_dot_score_keeper.sv
// tb/tb_dot_score_keeper.sv - directed bench with an integer reference model of dot_score_keeper
module tb_dot_score_keeper;
  localparam int DOT_POINTS  = 10;
  localparam int CLEAR_DELAY = 120;
  localparam int RELOAD_LEN  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic [143:0] map = '0;
  logic         ls = 1'b1;
  logic [19:0]  score_bcd_o;
  logic [7:0]   dots_left_o;
  logic [3:0]   level_num_o;
  logic         level_clear_o;
  logic         dots_reset_o;

  int errors = 0;
  int checks = 0;
  int rcnt   = 0;

  logic [143:0] full36;
  assign full36 = {108'd0, {36{1'b1}}};

  dot_score_keeper #(
    .DOT_POINTS(DOT_POINTS), .CLEAR_DELAY(CLEAR_DELAY), .RELOAD_LEN(RELOAD_LEN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .dot_display_i(map),
    .level_status_i(ls), .score_bcd_o(score_bcd_o), .dots_left_o(dots_left_o),
    .level_num_o(level_num_o), .level_clear_o(level_clear_o), .dots_reset_o(dots_reset_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: phases 0=init 1=play 2=clear wait 3=reload, plain integer arithmetic.
  int m_score, m_pend, m_dots, m_level, m_phase, m_cnt;
  logic [143:0] m_prev;

  always @(posedge clk or posedge rst) begin : model
    int n;
    bit go_wait;
    if (rst) begin
      m_score = 0; m_pend = 0; m_dots = 0; m_level = 1; m_phase = 0; m_cnt = 0; m_prev = '0;
    end else begin
      n = $countones(m_prev & ~map);
      if (m_pend > 0) m_score = (m_score + DOT_POINTS > 99999) ? 99999 : m_score + DOT_POINTS;
      case (m_phase)
        0: begin m_dots = $countones(map); m_pend = 0; m_phase = 1; end
        1: begin
          go_wait = !ls && m_pend == 0 && n == 0;
          m_pend = m_pend + n - ((m_pend > 0) ? 1 : 0);
          if (m_pend > 255) m_pend = 255;
          m_dots = (n > m_dots) ? 0 : m_dots - n;
          if (go_wait) begin m_phase = 2; m_cnt = 0; end
        end
        2: if (tick) begin
          m_cnt++;
          if (m_cnt == CLEAR_DELAY) begin
            m_phase = 3; m_cnt = 0;
            m_level = (m_level >= 15) ? 15 : m_level + 1;
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt == RELOAD_LEN) m_phase = 0;
        end
      endcase
      m_prev = map;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_score", 32'(score_bcd_o), to_bcd(m_score));
      check("m_dots_left", 32'(dots_left_o), 32'(m_dots));
      check("m_level", 32'(level_num_o), 32'(m_level));
      check("m_level_clear", 32'(level_clear_o), 32'(m_phase == 2));
      check("m_dots_reset", 32'(dots_reset_o), 32'(m_phase == 3));
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Also plays the dot grid: a reload pulse restores the 36-dot map.
  task automatic grid_step();
    step(1);
    if (dots_reset_o) begin
      rcnt++;
      map = full36;
      ls = 1'b1;
    end
  endtask

  task automatic eat(input int k);
    map = '0;
    for (int i = 0; i < k; i++) map[i] = 1'b1;
    step(1);
    map = '0;
    step(k + 3);
  endtask

  task automatic wait_clear(input int budget);
    int k = 0;
    while (!level_clear_o && k < budget) begin
      step(1);
      k++;
    end
    check("wait_level_clear", 32'(level_clear_o), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_score"}, 32'(score_bcd_o), 32'h0);
    check({tag, "_dots_left"}, 32'(dots_left_o), 32'd0);
    check({tag, "_level"}, 32'(level_num_o), 32'd1);
    check({tag, "_level_clear"}, 32'(level_clear_o), 32'd0);
    check({tag, "_dots_reset"}, 32'(dots_reset_o), 32'd0);
  endtask

  initial begin
    map = full36;
    #3 rst = 1'b1;
    #1 check_reset_vals("rst_async");
    step(2);
    rst = 1'b0;
    step(2);
    check("init_dots_left", 32'(dots_left_o), 32'd36);

    map[0] = 1'b0;
    step(1);
    check("one_dot_dots_left", 32'(dots_left_o), 32'd35);
    check("one_dot_score_n1", 32'(score_bcd_o), 32'h0);
    step(1);
    check("one_dot_score_n2", 32'(score_bcd_o), 32'h10);

    map[3:1] = 3'b000;
    step(1);
    check("three_dots_left", 32'(dots_left_o), 32'd32);
    check("three_dots_score0", 32'(score_bcd_o), 32'h10);
    step(3);
    check("three_dots_score3", 32'(score_bcd_o), 32'h40);
    step(1);
    check("three_dots_hold", 32'(score_bcd_o), 32'h40);

    map = '0;
    ls = 1'b0;
    wait_clear(100);
    check("clear_score", 32'(score_bcd_o), 32'h360);
    rcnt = 0;
    for (int i = 0; i < CLEAR_DELAY; i++) begin
      if (i == CLEAR_DELAY - 1) check("still_waiting", 32'(level_clear_o), 32'd1);
      tick = 1'b1;
      grid_step();
      tick = 1'b0;
      grid_step();
    end
    repeat (10) grid_step();
    check("reload_pulse_len", 32'(rcnt), 32'd2);
    check("level_two", 32'(level_num_o), 32'd2);
    check("reload_dots_left", 32'(dots_left_o), 32'd36);
    check("reload_clear_off", 32'(level_clear_o), 32'd0);

    for (int i = 0; i < 69; i++) eat(144);
    eat(27);
    check("score_99990", 32'(score_bcd_o), 32'h99990);
    check("dots_left_floor", 32'(dots_left_o), 32'd0);
    eat(2);
    check("score_sat", 32'(score_bcd_o), 32'h99999);
    eat(1);
    check("score_sat_hold", 32'(score_bcd_o), 32'h99999);

    ls = 1'b0;
    wait_clear(50);
    repeat (5) begin
      tick = 1'b1;
      grid_step();
      tick = 1'b0;
      grid_step();
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals("rst_in_wait");
    step(2);
    rst = 1'b0;
    map = full36;
    ls = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick = (i % 2 == 0);
      grid_step();
    end
    tick = 1'b0;
    check("no_stale_reload", 32'(rcnt), 32'd0);
    check("post_rst_dots_left", 32'(dots_left_o), 32'd36);
    check("post_rst_level", 32'(level_num_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
